// File: rtl/dsc_mul_seq.sv
// Operand sequencer and result capture for dsc_mul: one multiply in flight, valid/ready on both sides.
// State table: IDLE = accept operands | CLEAR = reset dsc_mul | RUN = dsc_mul enabled | DONE = result held.
module dsc_mul_seq #(
  parameter int NUM_BITS    = 10,
  parameter int CYC_W       = 21,
  parameter int TIMEOUT_CYC = (1 << 20) + 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_BITS-1:0]   in_a,
  input  logic [NUM_BITS-1:0]   in_b,
  output logic                  mul_rst,
  output logic                  mul_en,
  output logic [NUM_BITS-1:0]   mul_a,
  output logic [NUM_BITS-1:0]   mul_b,
  input  logic [2*NUM_BITS-1:0] mul_z,
  input  logic                  mul_ov,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*NUM_BITS-1:0] out_z,
  output logic [CYC_W-1:0]      out_cycles,
  output logic                  out_timeout,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  localparam logic [CYC_W-1:0] TO_CNT = CYC_W'(TIMEOUT_CYC);

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mul_rst_q, mul_rst_d;
  logic                  mul_en_q, mul_en_d;
  logic [NUM_BITS-1:0]   a_q, a_d, b_q, b_d;
  logic [CYC_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  out_valid_q, out_valid_d;
  logic [2*NUM_BITS-1:0] z_q, z_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic                  to_q, to_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mul_rst_q   <= 1'b1;
      mul_en_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      cyc_q       <= '0;
      to_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mul_rst_q   <= mul_rst_d;
      mul_en_q    <= mul_en_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      cyc_q       <= cyc_d;
      to_q        <= to_d;
      busy_q      <= busy_d;
    end
  end

  // All outputs are registered, so each branch sets the values for the state being entered.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    mul_rst_d   = mul_rst_q;
    mul_en_d    = mul_en_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    cyc_d       = cyc_q;
    to_d        = to_q;
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        mul_rst_d  = 1'b1;
        mul_en_d   = 1'b0;
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          a_d        = in_a;
          b_d        = in_b;
          if (in_a == '0 || in_b == '0) begin
            state_d     = S_DONE;
            mul_rst_d   = 1'b0;
            out_valid_d = 1'b1;
            z_d         = '0;
            cyc_d       = '0;
            to_d        = 1'b0;
          end else begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end
        end
      end
      S_CLEAR: begin
        state_d   = S_RUN;
        mul_rst_d = 1'b0;
        mul_en_d  = 1'b1;
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (mul_ov) begin
          state_d     = S_DONE;
          mul_en_d    = 1'b0;
          out_valid_d = 1'b1;
          z_d         = mul_z;
          cyc_d       = cnt_inc;
          to_d        = 1'b0;
        end else if (cnt_inc == TO_CNT) begin
          state_d     = S_DONE;
          mul_en_d    = 1'b0;
          out_valid_d = 1'b1;
          z_d         = '0;
          cyc_d       = TO_CNT;
          to_d        = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          mul_rst_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign in_ready    = in_ready_q;
  assign mul_rst     = mul_rst_q;
  assign mul_en      = mul_en_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign out_valid   = out_valid_q;
  assign out_z       = z_q;
  assign out_cycles  = cyc_q;
  assign out_timeout = to_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Bench for dsc_mul_seq: behavioural dsc_mul stub with programmable latency, result model from
// operands and latency, randomized transactions plus directed boundary cases.
module tb_dsc_mul_seq;

  localparam int NB  = 10;
  localparam int CW  = 21;
  localparam int TOC = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [NB-1:0] in_a, in_b;
  logic          mul_rst, mul_en;
  logic [NB-1:0] mul_a, mul_b;
  logic [2*NB-1:0] mul_z;
  logic          mul_ov;
  logic          out_valid, out_ready;
  logic [2*NB-1:0] out_z;
  logic [CW-1:0] out_cycles;
  logic          out_timeout, busy;

  dsc_mul_seq #(.NUM_BITS(NB), .CYC_W(CW), .TIMEOUT_CYC(TOC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_z(mul_z), .mul_ov(mul_ov),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_cycles(out_cycles), .out_timeout(out_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // dsc_mul stand-in: raises ov (and holds it) after stub_lat enabled cycles.
  int        stub_lat;
  bit        stub_never;
  bit        force_ov;
  int        s_cnt;
  logic      s_ov;
  logic [2*NB-1:0] s_z;

  always @(posedge clk) begin
    if (mul_rst) begin
      s_cnt <= 0;
      s_ov  <= 1'b0;
      s_z   <= '0;
    end else if (mul_en && !s_ov && !stub_never) begin
      s_cnt <= s_cnt + 1;
      if (s_cnt + 1 == stub_lat) begin
        s_ov <= 1'b1;
        s_z  <= (2*NB)'(mul_a) * (2*NB)'(mul_b);
      end
    end
  end

  assign mul_ov = s_ov | force_ov;
  assign mul_z  = s_z;

  int        en_total  = 0;
  int        mon_total = 0;
  bit        mon_on    = 1'b0;
  logic [NB-1:0] exp_a, exp_b;

  always @(negedge clk) begin
    if (mul_en) en_total++;
    if (mon_on && (mul_a !== exp_a || mul_b !== exp_b)) mon_total++;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [NB-1:0] a, input logic [NB-1:0] b, input int lat,
                         input bit never, input int hold, input bit clr_ov, output int cyc_o);
    logic [2*NB-1:0] ez, capz;
    int  ec, got, ready_err, hold_err, en0, mon0;
    bit  eto, zero;
    zero = (a == 0) || (b == 0);
    if (zero) begin
      ez = '0; ec = 0; eto = 1'b0;
    end else if (!never && lat + 1 <= TOC) begin
      ez = (2*NB)'(a) * (2*NB)'(b); ec = lat + 1; eto = 1'b0;
    end else begin
      ez = '0; ec = TOC; eto = 1'b1;
    end

    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    stub_lat   = lat;
    stub_never = never;
    in_valid   = 1'b1;
    in_a       = a;
    in_b       = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = NB'($urandom);
    in_b     = NB'($urandom);
    en0      = en_total;
    mon0     = mon_total;
    exp_a    = a;
    exp_b    = b;
    mon_on   = !zero;
    if (clr_ov) force_ov = 1'b1;
    if (hold == 0) out_ready = 1'b1;
    ready_err = 0;
    got       = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 2) force_ov = 1'b0;
      if (in_ready) ready_err++;
      if (out_valid) begin
        got = i;
        break;
      end
    end
    force_ov = 1'b0;
    chk("latency", got, zero ? 1 : ec + 2);
    capz = out_z;
    chk("out_z", out_z, ez);
    chk("out_cycles", out_cycles, ec);
    chk("out_timeout", out_timeout, eto);
    chk("mul_en_cycles", en_total - en0, ec);

    if (hold > 0) begin
      in_valid = 1'b1;
      in_a     = 2;
      in_b     = 2;
      hold_err = 0;
      repeat (hold) begin
        @(negedge clk);
        if (!out_valid || out_z !== capz || in_ready) hold_err++;
      end
      in_valid = 1'b0;
      chk("hold_stable", hold_err, 0);
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    mon_on    = 1'b0;
    chk("ready_while_busy", ready_err, 0);
    if (!zero) chk("mul_ab_stable", mon_total - mon0, 0);
    @(negedge clk);
    chk("post_handshake", {in_ready, out_valid, busy}, 3'b100);
    cyc_o = ec;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {in_ready, out_valid, out_timeout, mul_rst, mul_en, busy}, 6'b000100);
    chk({tag, "_data"}, {out_z, out_cycles, mul_a, mul_b}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, sum, nz;
    logic [NB-1:0] ra, rb;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b0;
    force_ov   = 1'b0;
    stub_lat   = 1;
    stub_never = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    #1;
    chk("in_ready_pre_edge", in_ready, 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", in_ready, 1);

    run_txn(10'd15, 10'd15, 5, 1'b0, 0, 1'b0, cyc);
    run_txn(10'd0, 10'd773, 5, 1'b0, 0, 1'b0, cyc);
    run_txn(10'd1023, 10'd1023, 12, 1'b0, 50, 1'b0, cyc);
    run_txn(10'd37, 10'd11, 1, 1'b1, 0, 1'b0, cyc);
    run_txn(10'd100, 10'd200, TOC - 1, 1'b0, 0, 1'b0, cyc);
    run_txn(10'd100, 10'd201, TOC, 1'b0, 0, 1'b0, cyc);
    run_txn(10'd7, 10'd9, 3, 1'b0, 0, 1'b1, cyc);

    // Abort mid-RUN, then make sure nothing of the lost operation leaks into the next one.
    @(negedge clk);
    stub_lat   = 40;
    stub_never = 1'b0;
    in_valid   = 1'b1;
    in_a       = 10'd500;
    in_b       = 10'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_run_busy", {busy, mul_en}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_run_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_abort", in_ready, 1);
    run_txn(10'd3, 10'd5, 4, 1'b0, 0, 1'b0, cyc);

    sum = 0;
    nz  = 0;
    for (int i = 0; i < 10; i++) begin
      ra = NB'($urandom_range(0, 1023));
      rb = NB'($urandom_range(0, 1023));
      run_txn(ra, rb, $urandom_range(1, 40), 1'b0, 0, 1'b0, cyc);
      sum += cyc;
      nz++;
    end
    $display("mean out_cycles over random pairs = %0d", sum / nz);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
